// File: rtl/mc_controller.sv
// Multicycle ARM control FSM: sequences the datapath and owns NZCV.
// Optional BL link write enabled by defining MC_CTRL_BL_EN.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
`ifdef MC_CTRL_BL_EN
  ,
  output logic       LinkWrite
`endif
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  state_t     r_state;
  logic [3:0] r_flags;

  logic       w_irw;
  logic       w_adr;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_res;
  logic       w_nextpc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic       w_aluop;
  logic [1:0] w_cmdctl;
  logic       w_nowrite;
  logic [1:0] w_flagw;
  logic       w_condex;
  logic       w_pcs;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condex = 1'b0;
    unique case (Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // NoWrite is decoded from cmd alone; it is consumed in ALUWB
  always_comb begin
    w_cmdctl  = 2'b00;
    w_nowrite = 1'b1;
    unique case (Funct[4:1])
      4'b0100: begin w_cmdctl = 2'b00; w_nowrite = 1'b0; end
      4'b0010: begin w_cmdctl = 2'b01; w_nowrite = 1'b0; end
      4'b0000: begin w_cmdctl = 2'b10; w_nowrite = 1'b0; end
      4'b1100: begin w_cmdctl = 2'b11; w_nowrite = 1'b0; end
      4'b1010: begin w_cmdctl = 2'b01; w_nowrite = 1'b1; end
      default: begin w_cmdctl = 2'b00; w_nowrite = 1'b1; end
    endcase
  end

  always_comb begin
    w_irw    = 1'b0;
    w_adr    = 1'b0;
    w_srca   = 2'b00;
    w_srcb   = 2'b00;
    w_res    = 2'b00;
    w_nextpc = 1'b0;
    w_regw   = 1'b0;
    w_memw   = 1'b0;
    w_branch = 1'b0;
    w_aluop  = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_irw    = 1'b1;
        w_srca   = 2'b01;
        w_srcb   = 2'b10;
        w_res    = 2'b10;
        w_nextpc = 1'b1;
      end
      DECODE: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_res  = 2'b10;
      end
      MEMADR:   w_srcb = 2'b01;
      MEMRD:    w_adr = 1'b1;
      MEMWB: begin
        w_res  = 2'b01;
        w_regw = 1'b1;
      end
      MEMWR: begin
        w_adr  = 1'b1;
        w_memw = 1'b1;
      end
      EXECUTER: w_aluop = 1'b1;
      EXECUTEI: begin
        w_srcb  = 2'b01;
        w_aluop = 1'b1;
      end
      ALUWB:    w_regw = ~w_nowrite;
      BRANCH: begin
        w_srcb   = 2'b01;
        w_res    = 2'b10;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_flagw = (w_aluop & Funct[0]) ?
                   (w_cmdctl[1] ? 2'b10 : 2'b11) : 2'b00;
  assign w_pcs   = w_branch | (w_regw & (Rd == 4'd15));

  assign PCWrite    = ~reset & ((w_pcs & w_condex) | w_nextpc);
  assign RegWrite   = ~reset & w_regw & w_condex;
  assign MemWrite   = ~reset & w_memw & w_condex;
  assign IRWrite    = ~reset & w_irw;
  assign AdrSrc     = w_adr;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign ALUSrcA    = w_srca;
  assign ALUSrcB    = w_srcb;
  assign ResultSrc  = w_res;
  assign ImmSrc     = Op;
  assign ALUControl = w_aluop ? w_cmdctl : 2'b00;
  assign Flags      = r_flags;

`ifdef MC_CTRL_BL_EN
  assign LinkWrite = ~reset & w_branch & Funct[4] & w_condex;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_flags <= 4'b0000;
    end else begin
      if (w_flagw[1] & w_condex)
        r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagw[0] & w_condex)
        r_flags[1:0] <= ALUFlags[1:0];
      unique case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          unique case (Op)
            2'b01:   r_state <= MEMADR;
            2'b00:   r_state <= Funct[5] ? EXECUTEI : EXECUTER;
            2'b10:   r_state <= BRANCH;
            default: r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:    r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        MEMWR:    r_state <= FETCH;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        ALUWB:    r_state <= FETCH;
        BRANCH:   r_state <= FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

endmodule
